// File: rtl/mbisr_repair_ctrl.sv
// mbisr_repair_ctrl
// Repair half of the MBIST/MBISR pair. Failing word addresses reported by the
// BIST engine are collected into a small spare-row table. Once the run is closed
// the table is locked, and functional accesses that hit a recorded address are
// steered to the matching spare row. Overflow of the table is flagged as
// unrepairable and stays set until the next clear or reset.
module mbisr_repair_ctrl #(
    parameter  int ADDR_W     = 6,
    parameter  int NUM_SPARES = 2,
    localparam int SIDX_W     = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1,
    localparam int CNT_W      = $clog2(NUM_SPARES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_fail_valid,
    input  logic [ADDR_W-1:0] i_fail_addr,
    output logic              o_fail_ready,
    input  logic              i_bist_done,
    input  logic              i_acc_valid,
    input  logic [ADDR_W-1:0] i_acc_addr,
    output logic              o_out_valid,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_out_spare_hit,
    output logic [SIDX_W-1:0] o_out_spare_idx,
    output logic [CNT_W-1:0]  o_spares_used,
    output logic              o_repair_ok,
    output logic              o_unrepairable
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_entry     [NUM_SPARES];
    logic [ADDR_W-1:0]   w_entry_nxt [NUM_SPARES];
    logic [NUM_SPARES-1:0] r_valid;
    logic [NUM_SPARES-1:0] w_valid_nxt;
    logic [CNT_W-1:0]    r_used;
    logic [CNT_W-1:0]    w_used_nxt;
    logic                r_unrep;
    logic                w_unrep_nxt;
    logic                r_repair_ok;
    logic                w_repair_ok_nxt;

    logic                w_fail_ready;
    logic                w_accept;
    logic                w_dup;
    logic                w_full;
    logic                w_hit;
    logic [SIDX_W-1:0]   w_idx;

    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_out_hit;
    logic [SIDX_W-1:0]   r_out_idx;

    // State register: synchronous reset returns to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: clear dominates, bist_done only closes an open collection.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = ST_COLLECT;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_IDLE;
                ST_COLLECT: w_state_nxt = i_bist_done ? ST_LOCKED : ST_COLLECT;
                ST_LOCKED:  w_state_nxt = ST_LOCKED;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State-derived outputs: ready only while collecting; repair_ok follows the next state.
    always_comb begin
        w_fail_ready    = (r_state == ST_COLLECT);
        w_repair_ok_nxt = (w_state_nxt == ST_LOCKED) & ~w_unrep_nxt;
    end

    // Table update: duplicate filter, in-order allocation, overflow flag.
    always_comb begin
        w_accept    = i_fail_valid & w_fail_ready & ~i_clear;
        w_full      = (r_used == CNT_W'(NUM_SPARES));
        w_dup       = 1'b0;
        w_entry_nxt = r_entry;
        w_valid_nxt = r_valid;
        w_used_nxt  = r_used;
        w_unrep_nxt = r_unrep;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (r_valid[i] && (r_entry[i] == i_fail_addr)) begin
                w_dup = 1'b1;
            end else begin
                w_dup = w_dup;
            end
        end
        if (i_clear) begin
            w_valid_nxt = '0;
            w_used_nxt  = '0;
            w_unrep_nxt = 1'b0;
        end else if (w_accept && !w_dup) begin
            if (!w_full) begin
                for (int i = 0; i < NUM_SPARES; i++) begin
                    if (r_used == CNT_W'(i)) begin
                        w_entry_nxt[i] = i_fail_addr;
                        w_valid_nxt[i] = 1'b1;
                    end else begin
                        w_entry_nxt[i] = r_entry[i];
                    end
                end
                w_used_nxt = r_used + CNT_W'(1);
            end else begin
                w_unrep_nxt = 1'b1;
            end
        end else begin
            w_used_nxt = r_used;
        end
    end

    // Table and status registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SPARES; i++) begin
                r_entry[i] <= '0;
            end
            r_valid     <= '0;
            r_used      <= '0;
            r_unrep     <= 1'b0;
            r_repair_ok <= 1'b0;
        end else begin
            r_entry     <= w_entry_nxt;
            r_valid     <= w_valid_nxt;
            r_used      <= w_used_nxt;
            r_unrep     <= w_unrep_nxt;
            r_repair_ok <= w_repair_ok_nxt;
        end
    end

    // Lookup match: only a locked table remaps; the lowest matching index wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SPARES - 1; i >= 0; i--) begin
            if ((r_state == ST_LOCKED) && r_valid[i] && (r_entry[i] == i_acc_addr)) begin
                w_hit = 1'b1;
                w_idx = SIDX_W'(i);
            end else begin
                w_hit = w_hit;
            end
        end
    end

    // Lookup result register: one-cycle latency, fields hold between accesses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_hit   <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_out_valid <= i_acc_valid;
            if (i_acc_valid) begin
                r_out_addr <= i_acc_addr;
                r_out_hit  <= w_hit;
                r_out_idx  <= w_idx;
            end else begin
                r_out_addr <= r_out_addr;
                r_out_hit  <= r_out_hit;
                r_out_idx  <= r_out_idx;
            end
        end
    end

    assign o_fail_ready    = w_fail_ready;
    assign o_out_valid     = r_out_valid;
    assign o_out_addr      = r_out_addr;
    assign o_out_spare_hit = r_out_hit;
    assign o_out_spare_idx = r_out_idx;
    assign o_spares_used   = r_used;
    assign o_repair_ok     = r_repair_ok;
    assign o_unrepairable  = r_unrep;

endmodule

// File: tb/tb_mbisr_repair_ctrl.sv
// Bench for mbisr_repair_ctrl: directed scenarios followed by random traffic,
// checked against a queue-based reference model with a lookup scoreboard.
module tb_mbisr_repair_ctrl;

    logic       clk = 1'b0;
    logic       rst, clear, fail_valid, bist_done, acc_valid;
    logic [5:0] fail_addr, acc_addr;
    logic       fail_ready, out_valid, out_hit, repair_ok, unrep;
    logic [5:0] out_addr;
    logic [0:0] out_idx;
    logic [1:0] spares_used;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [5:0] addr;
        bit         hit;
        int         idx;
    } exp_t;
    exp_t exp_q[$];

    // reference model: 0 idle, 1 collecting, 2 locked; table is ordered list of faults
    int         m_state = 0;
    logic [5:0] m_tbl[$];
    bit         m_unrep = 1'b0;

    mbisr_repair_ctrl #(.ADDR_W(6), .NUM_SPARES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_fail_valid(fail_valid), .i_fail_addr(fail_addr), .o_fail_ready(fail_ready),
        .i_bist_done(bist_done), .i_acc_valid(acc_valid), .i_acc_addr(acc_addr),
        .o_out_valid(out_valid), .o_out_addr(out_addr),
        .o_out_spare_hit(out_hit), .o_out_spare_idx(out_idx),
        .o_spares_used(spares_used), .o_repair_ok(repair_ok), .o_unrepairable(unrep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every presented lookup result must match the oldest expectation
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL lookup_unexpected: got out_valid=1 expected no result");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("lookup_addr", int'(out_addr), int'(e.addr));
                chk("lookup_hit", int'(out_hit), int'(e.hit));
                chk("lookup_idx", int'(out_idx), e.idx);
            end
        end
    end

    task automatic model_step(input bit r, input bit c, input bit fv, input logic [5:0] fa,
                              input bit bd, input bit av, input logic [5:0] aa);
        exp_t e;
        int   pos;
        if (r) begin
            m_state = 0;
            m_tbl.delete();
            m_unrep = 1'b0;
            return;
        end
        if (av) begin
            pos = -1;
            if (m_state == 2)
                for (int i = 0; i < m_tbl.size(); i++)
                    if (pos < 0 && m_tbl[i] == aa) pos = i;
            e.addr = aa;
            e.hit  = (pos >= 0);
            e.idx  = (pos >= 0) ? pos : 0;
            exp_q.push_back(e);
        end
        if (c) begin
            m_state = 1;
            m_tbl.delete();
            m_unrep = 1'b0;
        end else if (m_state == 1) begin
            if (fv) begin
                bit seen = 1'b0;
                foreach (m_tbl[i]) if (m_tbl[i] == fa) seen = 1'b1;
                if (!seen) begin
                    if (m_tbl.size() < 2) m_tbl.push_back(fa);
                    else m_unrep = 1'b1;
                end
            end
            if (bd) m_state = 2;
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit fv, input logic [5:0] fa,
                       input bit bd, input bit av, input logic [5:0] aa);
        rst = r; clear = c; fail_valid = fv; fail_addr = fa;
        bist_done = bd; acc_valid = av; acc_addr = aa;
        model_step(r, c, fv, fa, bd, av, aa);
        @(posedge clk);
        #1;
        chk("spares_used", int'(spares_used), m_tbl.size());
        chk("unrepairable", int'(unrep), int'(m_unrep));
        chk("repair_ok", int'(repair_ok), int'(m_state == 2 && !m_unrep));
        chk("fail_ready", int'(fail_ready), int'(m_state == 1));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_addr", int'(out_addr), 0);
        chk("rst_out_hit", int'(out_hit), 0);
        chk("rst_out_idx", int'(out_idx), 0);
    endtask

    task automatic idle(); cyc(0, 0, 0, 6'd0, 0, 0, 6'd0); endtask
    task automatic report(input logic [5:0] a); cyc(0, 0, 1, a, 0, 0, 6'd0); endtask
    task automatic lookup(input logic [5:0] a); cyc(0, 0, 0, 6'd0, 0, 1, a); endtask
    task automatic do_clear(); cyc(0, 1, 0, 6'd0, 0, 0, 6'd0); endtask
    task automatic done(); cyc(0, 0, 0, 6'd0, 1, 0, 6'd0); endtask

    initial begin
        rst = 1'b1; clear = 1'b0; fail_valid = 1'b0; fail_addr = 6'd0;
        bist_done = 1'b0; acc_valid = 1'b0; acc_addr = 6'd0;

        // 1: single fault repaired
        cyc(1, 0, 0, 6'd0, 0, 0, 6'd0);
        chk_reset_outputs();
        do_clear(); report(6'd8); done();
        lookup(6'd8); lookup(6'd9); idle();
        chk("t1_repair_ok", int'(repair_ok), 1);

        // 2: two faults, second maps to spare 1
        do_clear(); report(6'd8); report(6'd42); done();
        chk("t2_used", int'(spares_used), 2);
        lookup(6'd42); idle();

        // 3: overflow
        do_clear(); report(6'd8); report(6'd42); report(6'd5); done(); idle();
        chk("t3_unrep", int'(unrep), 1);
        chk("t3_repair_ok", int'(repair_ok), 0);
        lookup(6'd5); lookup(6'd8); idle();

        // 4: duplicates, last one together with bist_done
        do_clear(); report(6'd8); report(6'd8);
        cyc(0, 0, 1, 6'd8, 1, 0, 6'd0); idle();
        chk("t4_used", int'(spares_used), 1);

        // 5: clear beats a concurrent report; no remap while collecting
        do_clear(); report(6'd8);
        cyc(0, 1, 1, 6'd42, 0, 0, 6'd0);
        chk("t5_used", int'(spares_used), 0);
        lookup(6'd8); idle();

        // 6: reset while locked with two entries, pending lookup dropped
        do_clear(); report(6'd8); report(6'd42); done();
        cyc(1, 0, 0, 6'd0, 0, 1, 6'd8);
        chk_reset_outputs();
        lookup(6'd8); idle();
        chk("t6_fail_ready", int'(fail_ready), 0);
        // bist_done outside COLLECT ignored
        done(); lookup(6'd8); idle();

        // random traffic over a small address pool to force hits, duplicates and overflow
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
                $urandom_range(0, 1), 6'($urandom_range(0, 5)),
                ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                6'($urandom_range(0, 7)));
        end
        idle(); idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
